conv_accumulator: RTL and testbench

//  - Downstream of the convolution iterator. Consumes its en_sum / en_save / finish

---
 rtl/conv_accumulator.sv | 92 +++++++++
 tb/tb_conv_accumulator.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/conv_accumulator.sv
// conv_accumulator: signed MAC per output point feeding a FWFT result FIFO; optional ReLU on pushed results via CONV_RELU_EN
module conv_accumulator #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en_sum,
    input  logic                     en_save,
    input  logic                     finish,
    input  logic signed [DATA_W-1:0] pixel_in,
    input  logic signed [DATA_W-1:0] weight_in,
    output logic signed [ACC_W-1:0]  out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     stall,
    output logic                     overflow,
    output logic                     done
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {RUN, DRAIN, FIN} state_t;
    state_t                    state, state_nx;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]   acc, sum, push_val;
    logic signed [ACC_W-1:0]   mem [DEPTH];
    logic [AW-1:0]             wr_ptr, rd_ptr;
    logic [AW:0]               count;
    logic                      run, push_req, push, pop;
    assign prod = pixel_in * weight_in;
    // datapath: running sum, push/pop handshake and FIFO flags
    always_comb begin
        run       = state == RUN;
        sum       = en_sum ? acc + ACC_W'(prod) : acc;
`ifdef CONV_RELU_EN
        push_val  = sum[ACC_W-1] ? '0 : sum;
`else
        push_val  = sum;
`endif
        out_valid = count != '0;
        stall     = count == (AW+1)'(DEPTH);
        pop       = out_valid & out_ready;
        push_req  = run & en_save;
        push      = push_req & (~stall | pop);
        out_data  = out_valid ? mem[rd_ptr] : '0;
    end
    // accumulator clears on every save, whether or not the result was stored
    always_ff @(posedge clk) begin
        if (reset)
            acc <= '0;
        else if (run)
            acc <= en_save ? '0 : sum;
    end
    // result storage, no reset needed since out_data is masked when empty
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_val;
    end
    // FIFO pointers, occupancy and sticky overflow on a dropped save
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (push_req & stall & ~pop)
                overflow <= 1'b1;
        end
    end
    // state register
    always_ff @(posedge clk) begin
        if (reset)
            state <= RUN;
        else
            state <= state_nx;
    end
    // next state: stop on finish, complete once every result has been drained
    always_comb begin
        state_nx = (state == RUN && finish) ? DRAIN :
                   (state == DRAIN && !out_valid) ? FIN : state;
    end
    // outputs decoded from state
    always_comb begin
        done = state == FIN;
    end
endmodule

// File: tb/tb_conv_accumulator.sv
// tb_conv_accumulator: table-driven and scoreboard checks for conv_accumulator
module tb_conv_accumulator;
    logic clk = 0, reset = 1, en_sum = 0, en_save = 0, finish = 0, out_ready = 0;
    logic signed [7:0]  pixel_in = 0, weight_in = 0;
    logic signed [19:0] out_data;
    logic out_valid, stall, overflow, done;
    int total = 0, bad = 0;
    int sb[$];

    typedef struct {
        int n;
        int p[4];
        int w[4];
        bit merge;
        int exp;
    } vec_t;
    vec_t vt[7];

    conv_accumulator #(.DATA_W(8), .ACC_W(20), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .en_sum(en_sum), .en_save(en_save), .finish(finish),
        .pixel_in(pixel_in), .weight_in(weight_in), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .stall(stall),
        .overflow(overflow), .done(done)
    );

    always #5 clk = ~clk;

    function automatic int rl(input int x);
`ifdef CONV_RELU_EN
        return x < 0 ? 0 : x;
`else
        return x;
`endif
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // scoreboard: every accepted result must match the oldest expected value
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0)
                chk("pop_unexpected", $signed(out_data), -999999);
            else
                chk("pop_data", $signed(out_data), sb.pop_front());
        end
    end

    task automatic drive(input logic s, input logic v, input logic f, input int p, input int w);
        en_sum = s; en_save = v; finish = f;
        pixel_in = 8'(p); weight_in = 8'(w);
        @(posedge clk); #1;
        en_sum = 0; en_save = 0; finish = 0;
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1; en_sum = 0; en_save = 0; finish = 0; out_ready = 0;
        idle(); idle();
        reset = 0;
        sb.delete();
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 20 && out_valid; i++) idle();
        chk({nm, "_drained"}, int'(out_valid), 0);
        chk({nm, "_sb_empty"}, sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        vt[0] = '{3, '{1, 2, 3, 0}, '{4, 5, 6, 0}, 0, 32};
        vt[1] = '{2, '{2, 3, 0, 0}, '{5, 3, 0, 0}, 1, 19};
        vt[2] = '{2, '{-5, 2, 0, 0}, '{3, 1, 0, 0}, 0, -13};
        vt[3] = '{1, '{127, 0, 0, 0}, '{127, 0, 0, 0}, 1, 16129};
        vt[4] = '{4, '{-128, -128, 127, -1}, '{127, -128, -128, -1}, 0, -16127};
        vt[5] = '{0, '{0, 0, 0, 0}, '{0, 0, 0, 0}, 0, 0};
        vt[6] = '{2, '{4, -1, 0, 0}, '{-2, 7, 0, 0}, 1, -15};

        do_reset();
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_data", $signed(out_data), 0);
        chk("rst_stall", int'(stall), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_done", int'(done), 0);

        // table-driven points, consumer always ready
        out_ready = 1;
        for (int k = 0; k < 7; k++) begin
            for (int t = 0; t < vt[k].n - int'(vt[k].merge); t++)
                drive(1, 0, 0, vt[k].p[t], vt[k].w[t]);
            sb.push_back(rl(vt[k].exp));
            if (vt[k].merge)
                drive(1, 1, 0, vt[k].p[vt[k].n-1], vt[k].w[vt[k].n-1]);
            else
                drive(0, 1, 0, 0, 0);
            if (k == 0) begin
                chk("first_valid", int'(out_valid), 1);
                chk("first_data", $signed(out_data), rl(32));
            end
        end
        drain("table");

        // fill FIFO, drop fifth save, then drain in order
        do_reset();
        for (int i = 0; i < 4; i++) begin
            sb.push_back(rl((i + 1) * 10));
            drive(1, 1, 0, i + 1, 10);
        end
        chk("full_stall", int'(stall), 1);
        chk("full_no_ovf", int'(overflow), 0);
        drive(1, 1, 0, 9, 9);
        chk("ovf_set", int'(overflow), 1);
        chk("ovf_stall", int'(stall), 1);
        chk("ovf_head", $signed(out_data), 10);
        out_ready = 1;
        drain("ovf");
        chk("ovf_sticky", int'(overflow), 1);
        chk("ovf_stall_clr", int'(stall), 0);

        // simultaneous push and pop while full
        do_reset();
        for (int i = 0; i < 4; i++) begin
            sb.push_back(rl(100 + i));
            drive(1, 1, 0, 1, 100 + i);
        end
        out_ready = 1;
        sb.push_back(rl(25));
        drive(1, 1, 0, 5, 5);
        chk("pp_stall", int'(stall), 1);
        chk("pp_no_ovf", int'(overflow), 0);
        chk("pp_head", $signed(out_data), rl(101));
        drain("pp");

        // accumulator wrap: 32 terms -> -2^19, 64 terms -> 0
        do_reset();
        out_ready = 1;
        for (int i = 0; i < 32; i++) drive(1, 0, 0, -128, -128);
        sb.push_back(rl(-524288));
        drive(0, 1, 0, 0, 0);
        for (int i = 0; i < 64; i++) drive(1, 0, 0, -128, -128);
        sb.push_back(0);
        drive(0, 1, 0, 0, 0);
        drain("wrap");

        // finish with two queued results; strobe in DRAIN ignored
        do_reset();
        sb.push_back(rl(6));
        drive(1, 1, 0, 2, 3);
        sb.push_back(rl(-7));
        drive(1, 1, 1, -1, 7);
        chk("drain_not_done", int'(done), 0);
        drive(1, 1, 0, 9, 9);
        out_ready = 1;
        drain("fin");
        chk("fin_done_late", int'(done), 0);
        idle();
        chk("fin_done", int'(done), 1);
        idle(); idle();
        chk("fin_done_hold", int'(done), 1);

        // finish with an empty FIFO
        do_reset();
        drive(0, 0, 1, 0, 0);
        chk("empty_fin_wait", int'(done), 0);
        idle();
        chk("empty_fin_done", int'(done), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
